// File: rtl/parity_serial_checker.sv
// Serial parity checker: takes DATA_W data bits LSB-first and then one parity bit, and returns
// the word with a parity-error flag over a valid/ready port. It also keeps a saturating error count.
module parity_serial_checker #(
    parameter int DATA_W = 7,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic              s_sof,
    input  logic              s_bit,
    output logic              s_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_perr,
    output logic [7:0]        err_count,
    output logic              frame_abort
);

    // state | meaning
    // IDLE  | waiting for a bit marked s_sof; unmarked bits are dropped
    // RECV  | collecting data bits; the bit after bit DATA_W-1 is the parity bit
    // HOLD  | word presented on m_*, serial input stalled until the handshake

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              acc;
    logic              acc_next;
    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] shadow_next;
    logic              accept;
    logic              load_word;
    logic              restart;
    logic              word_perr;

    assign s_ready   = (state != HOLD);
    assign m_valid   = (state == HOLD);
    assign accept    = s_valid & s_ready;
    assign word_perr = acc ^ s_bit ^ ODD;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        acc_next    = acc;
        shadow_next = shadow;
        load_word   = 1'b0;
        restart     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && s_sof) begin
                    shadow_next[0] = s_bit;
                    cnt_next       = CNT_W'(1);
                    acc_next       = s_bit;
                    state_next     = RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    if (s_sof) begin
                        // Only bit 0 is rewritten. Stale upper bits are overwritten before the word is used.
                        restart        = 1'b1;
                        shadow_next[0] = s_bit;
                        cnt_next       = CNT_W'(1);
                        acc_next       = s_bit;
                    end else if (cnt == LAST_CNT) begin
                        load_word  = 1'b1;
                        state_next = HOLD;
                    end else begin
                        for (int i = 1; i < DATA_W; i++) begin
                            if (cnt == CNT_W'(i)) begin
                                shadow_next[i] = s_bit;
                            end
                        end
                        acc_next = acc ^ s_bit;
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= 1'b0;
            shadow      <= '0;
            m_data      <= '0;
            m_perr      <= 1'b0;
            err_count   <= 8'd0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            acc         <= acc_next;
            shadow      <= shadow_next;
            frame_abort <= restart;
            if (load_word) begin
                m_data <= shadow;
                m_perr <= word_perr;
                if (word_perr && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/parity_serial_checker.md
Name: parity_serial_checker

Overview:
Receive-side counterpart to the team's parity generators. Accepts a serial frame (DATA_W data bits LSB-first, then one parity bit), deserializes the data and checks it against the configured parity sense. Presents the data word plus an error flag on a valid/ready output port, and keeps a saturating count of parity errors. Sits between a serial link front-end and word-level consumers.

Parameters:
DATA_W, 7, number of data bits per frame (1..16)
ODD, 0, parity sense: 0 = even (XOR of all DATA_W+1 bits must be 0); 1 = odd (XOR must be 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, synchronous, active-low
s_valid  input  1  serial bit present on s_bit
s_sof  input  1  marks the first data bit of a frame; qualified by s_valid
s_bit  input  1  serial bit
s_ready  output  1  checker can accept a bit; a bit is accepted when s_valid & s_ready
m_valid  output  1  deserialized word available
m_ready  input  1  consumer accepts the word; handshake when m_valid & m_ready
m_data  output  DATA_W  received data word, bit 0 = first bit received
m_perr  output  1  parity error for the word on m_data
err_count  output  8  parity errors seen since reset, saturates at 255
frame_abort  output  1  one-cycle pulse: a frame was restarted by s_sof before it completed

Behaviour:
- One clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset, including mid-frame or mid-HOLD: state IDLE; bit counter and accumulator cleared; any partial or held frame discarded. Outputs: s_ready=1, m_valid=0, m_data=0, m_perr=0, err_count=0, frame_abort=0.
- States: IDLE, RECV, HOLD. s_ready = 1 in IDLE and RECV, 0 in HOLD (combinational from state).
- IDLE:
  - Accepted bit with s_sof=1: store it as data bit 0; cnt=1; acc=s_bit; go to RECV.
  - Accepted bit with s_sof=0: discarded, no state change.
- RECV, accepted bit with s_sof=1: restart. frame_abort=1 on the next cycle. The bit becomes data bit 0 of the new frame (cnt=1, acc=s_bit). Stale data bits above bit 0 need not be cleared, but m_data must not change until HOLD.
- RECV, accepted bit with s_sof=0 and cnt<DATA_W: m_data shadow[cnt]=s_bit; acc^=s_bit; cnt++.
- RECV, accepted bit with s_sof=0 and cnt==DATA_W: this is the parity bit.
  - perr = acc ^ s_bit ^ ODD.
  - Go to HOLD; m_valid, m_data and m_perr are registered and valid on the next cycle. Latency is 1 cycle from parity-bit acceptance to m_valid.
- RECV, cycles with s_valid=0: no change, no timeout.
- Entering HOLD with perr=1: err_count += 1, saturating at 255 (no wrap).
- HOLD:
  - m_valid=1; m_data and m_perr stable until the handshake.
  - m_valid & m_ready: go to IDLE; m_valid=0 next cycle. m_data and m_perr retain their last values.
  - s_valid is ignored while in HOLD, because s_ready=0.
- DATA_W=1: a frame is 2 bits, and cnt==DATA_W is reached directly after the sof bit.
- frame_abort is 0 in every cycle except the one following a restart.
- Throughput: at best DATA_W+1 bit cycles plus one HOLD cycle per frame.

Test Plan:
- Even parity, clean frame: ODD=0, DATA_W=7, with s_valid held 1. Bits 1,0,1,0,1,0,1 (s_sof on the first), then parity 0, with m_ready=1 -> m_valid=1 exactly one cycle after the parity bit, m_data=7'h55, m_perr=0, err_count=0; m_valid=0 on the following cycle.
- Parity error: same data with parity bit 1 -> m_data=7'h55, m_perr=1, err_count=1. A second bad frame -> err_count=2.
- Backpressure: complete a 7'h7F frame with parity 1 while m_ready=0 for 5 cycles, and drive s_valid=1, s_sof=1 during HOLD -> s_ready=0; m_valid, m_data=7'h7F and m_perr=0 stable all 5 cycles; the driven bits are ignored. Raise m_ready -> m_valid drops next cycle, s_ready=1.
- Abort/restart: s_sof at frame start, 3 bits sent, then s_sof again followed by a full 7'h03 frame with parity 0 -> frame_abort=1 for exactly one cycle; a single output word m_data=7'h03, m_perr=0.
- Reset and saturation: assert rst_n=0 for one cycle mid-RECV -> all outputs at reset values, and the next frame decodes correctly. Send 260 bad frames -> err_count stops at 255.
- Odd sense: ODD=1, data 7'h00 with parity 1 -> m_perr=0; data 7'h00 with parity 0 -> m_perr=1.
